cmp_search_ctrl: RTL and testbench

- Sequential initiator for the team's magnitude comparator. It drives the comparator's B operand (probe) and reads back its equal/greater/less flags for an unknown A operand.
- Runs a binary search that recovers the value of A in at most WIDTH+1 probes, then reports the result and the probe count.
- Sits beside the comparator in the ALU datapath and turns the combinational compare into a value-recovery / range-search engine.

---
 rtl/cmp_search_ctrl.sv | 177 +++++++++++++++++
 tb/tb_cmp_search_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/cmp_search_ctrl.sv
// cmp_search_ctrl
//   Binary-search initiator for a magnitude comparator. Drives the
//   comparator B operand (probe), samples equal/greater/less for the
//   unknown A operand each cycle, and recovers A in at most WIDTH+1
//   probes. Reports the recovered value and the probe count.
//
//   Optional build macro CMP_ONEHOT_CHK_EN: when defined, every sampled
//   flag triple must be exactly one-hot, otherwise the search ends with
//   an error. When undefined, flags resolve as equal > greater > less,
//   and no asserted flag counts as less.
module cmp_search_ctrl #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             cmp_equal,
   input  logic             cmp_greater,
   input  logic             cmp_less,
   output logic [WIDTH-1:0] probe,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] probe_cnt
);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_SEARCH = 1'b1
   } state_e;

   localparam logic [WIDTH:0]   MAX_BOUND = {1'b0, {WIDTH{1'b1}}};
   localparam logic [WIDTH-1:0] FIRST_PROBE = {1'b0, {(WIDTH-1){1'b1}}};

   state_e           state_q, state_d;
   logic [WIDTH-1:0] probe_q, probe_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH:0]   lo_q, lo_d;
   logic [WIDTH:0]   hi_q, hi_d;

   // Candidate bounds derived from the current probe.
   logic [WIDTH:0]   lo_inc;
   logic [WIDTH:0]   hi_dec;
   logic             flags_bad;
   logic             take_eq;
   logic             take_gt;

   // Midpoint of two WIDTH+1 bit bounds, summed without overflow.
   function automatic logic [WIDTH-1:0] mid_of(input logic [WIDTH:0] a,
                                                input logic [WIDTH:0] b);
      logic [WIDTH+1:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return WIDTH'(sum >> 1);
   endfunction

   // Flag decode; the one-hot check only exists in the checked build.
   always_comb begin
      lo_inc  = {1'b0, probe_q} + (WIDTH+1)'(1);
      hi_dec  = {1'b0, probe_q} - (WIDTH+1)'(1);
`ifdef CMP_ONEHOT_CHK_EN
      flags_bad = !(({cmp_equal, cmp_greater, cmp_less} == 3'b100) ||
                    ({cmp_equal, cmp_greater, cmp_less} == 3'b010) ||
                    ({cmp_equal, cmp_greater, cmp_less} == 3'b001));
`else
      flags_bad = 1'b0;
`endif
      take_eq = cmp_equal;
      take_gt = !cmp_equal && cmp_greater;
   end

   // Next-state and output logic for the IDLE/SEARCH controller.
   always_comb begin
      state_d  = state_q;
      probe_d  = probe_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      result_d = result_q;
      cnt_d    = cnt_q;
      lo_d     = lo_q;
      hi_d     = hi_q;

      unique case (state_q)
         ST_IDLE: begin
            busy_d = 1'b0;
            if (start) begin
               lo_d    = '0;
               hi_d    = MAX_BOUND;
               probe_d = FIRST_PROBE;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = ST_SEARCH;
            end
         end

         ST_SEARCH: begin
            cnt_d = cnt_q + WIDTH'(1);
            if (flags_bad) begin
               done_d  = 1'b1;
               err_d   = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else if (take_eq) begin
               result_d = probe_q;
               done_d   = 1'b1;
               busy_d   = 1'b0;
               state_d  = ST_IDLE;
            end else if (take_gt) begin
               // lo_inc reaches 2^WIDTH after probing the maximum.
               if (lo_inc > hi_q) begin
                  done_d  = 1'b1;
                  err_d   = 1'b1;
                  busy_d  = 1'b0;
                  state_d = ST_IDLE;
               end else begin
                  lo_d    = lo_inc;
                  probe_d = mid_of(lo_inc, hi_q);
               end
            end else begin
               // Probe 0 would drive hi to -1; hi_dec wraps, so test it first.
               if ((probe_q == '0) || (hi_dec < lo_q)) begin
                  done_d  = 1'b1;
                  err_d   = 1'b1;
                  busy_d  = 1'b0;
                  state_d = ST_IDLE;
               end else begin
                  hi_d    = hi_dec;
                  probe_d = mid_of(lo_q, hi_dec);
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         probe_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         result_q <= '0;
         cnt_q    <= '0;
         lo_q     <= '0;
         hi_q     <= '0;
      end else begin
         state_q  <= state_d;
         probe_q  <= probe_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
         result_q <= result_d;
         cnt_q    <= cnt_d;
         lo_q     <= lo_d;
         hi_q     <= hi_d;
      end
   end

   assign probe     = probe_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign result    = result_q;
   assign probe_cnt = cnt_q;

endmodule

// File: tb/tb_cmp_search_ctrl.sv
// tb_cmp_search_ctrl
//   Directed bench for cmp_search_ctrl (WIDTH = 4) with a behavioural
//   comparator. Expected probe sequences and results are hand-computed.
//   Honours CMP_ONEHOT_CHK_EN for the illegal-flag scenario.
module tb_cmp_search_ctrl;

   localparam int unsigned W = 4;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic         cmp_equal;
   logic         cmp_greater;
   logic         cmp_less;
   logic [W-1:0] probe;
   logic         busy;
   logic         done;
   logic         err;
   logic [W-1:0] result;
   logic [W-1:0] probe_cnt;

   // Comparator model: 0 = true compare against a_val,
   // 1 = greater always, 2 = greater and less together.
   int unsigned  mode;
   logic [W-1:0] a_val;

   int n_checks;
   int n_errors;
   int exp_probes[$];

   cmp_search_ctrl #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .cmp_equal   (cmp_equal),
      .cmp_greater (cmp_greater),
      .cmp_less    (cmp_less),
      .probe       (probe),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .result      (result),
      .probe_cnt   (probe_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural comparator driven from the registered probe.
   always_comb begin
      cmp_equal   = 1'b0;
      cmp_greater = 1'b0;
      cmp_less    = 1'b0;
      case (mode)
         0: begin
            cmp_equal   = (a_val == probe);
            cmp_greater = (a_val >  probe);
            cmp_less    = (a_val <  probe);
         end
         1: cmp_greater = 1'b1;
         default: begin
            cmp_greater = 1'b1;
            cmp_less    = 1'b1;
         end
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Pulse start, follow the probe sequence in exp_probes, then check
   // the completion outputs and that done/err last exactly one cycle.
   task automatic run_search(input string tag, input int exp_cnt, input int exp_res,
                             input bit exp_err, input bit poke_start);
      bit seen;
      seen = 1'b0;
      @(negedge clk);
      start = 1'b1;
      for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
         @(negedge clk);
         if (cyc == 0) start = 1'b0;
         if (done) begin
            seen = 1'b1;
            check({tag, "_latency"}, cyc, exp_cnt);
            check({tag, "_err"}, err, exp_err);
            check({tag, "_result"}, result, exp_res);
            check({tag, "_cnt"}, probe_cnt, exp_cnt);
            check({tag, "_busy_end"}, busy, 0);
         end else begin
            check({tag, "_busy"}, busy, 1);
            if (cyc < exp_probes.size())
               check($sformatf("%s_probe%0d", tag, cyc), probe, exp_probes[cyc]);
            if (poke_start && cyc == 1) start = 1'b1;
            if (poke_start && cyc == 2) start = 1'b0;
         end
      end
      start = 1'b0;
      if (!seen) check({tag, "_timeout"}, 0, 1);
      @(negedge clk);
      check({tag, "_done_pulse"}, done, 0);
      check({tag, "_err_pulse"}, err, 0);
      check({tag, "_idle"}, busy, 0);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      mode     = 0;
      a_val    = '0;
      start    = 1'b0;
      rst_n    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_probe", probe, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_result", result, 0);
      check("rst_cnt", probe_cnt, 0);
      @(negedge clk);
      rst_n = 1'b1;

      a_val = 4'd9;
      exp_probes = '{7, 11, 9};
      run_search("a9", 3, 9, 1'b0, 1'b0);

      a_val = 4'd15;
      exp_probes = '{7, 11, 13, 14, 15};
      run_search("a15", 5, 15, 1'b0, 1'b0);

      // Error leaves the previous result (15) in place.
      mode = 1;
      exp_probes = '{7, 11, 13, 14, 15};
      run_search("gt_always", 5, 15, 1'b1, 1'b0);
      mode = 0;

      a_val = 4'd0;
      exp_probes = '{7, 3, 1, 0};
      run_search("a0", 4, 0, 1'b0, 1'b0);

      a_val = 4'd9;
      exp_probes = '{7, 11, 9};
      run_search("a9_poke", 3, 9, 1'b0, 1'b1);

      // Reset asserted while the second probe is on the bus.
      a_val = 4'd9;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("mid_probe0", probe, 7);
      @(negedge clk);
      check("mid_probe1", probe, 11);
      rst_n = 1'b0;
      #1;
      check("mid_rst_probe", probe, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_result", result, 0);
      check("mid_rst_cnt", probe_cnt, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("mid_rst_nodone", done, 0);
      end
      rst_n = 1'b1;
      a_val = 4'd5;
      exp_probes = '{7, 3, 5};
      run_search("after_rst", 3, 5, 1'b0, 1'b0);

      a_val = 4'd15;
      exp_probes = '{7, 11, 13, 14, 15};
      run_search("a15b", 5, 15, 1'b0, 1'b0);

      // Greater and less asserted together.
      mode = 2;
`ifdef CMP_ONEHOT_CHK_EN
      exp_probes = '{7};
      run_search("bad_flags", 1, 15, 1'b1, 1'b0);
`else
      exp_probes = '{7, 11, 13, 14, 15};
      run_search("bad_flags", 5, 15, 1'b1, 1'b0);
`endif
      mode = 0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
